mul_nibble_seq: RTL

MUL_NIBBLE_SEQ -- requirements
Module: mul_nibble_seq

---
 rtl/mul_nibble_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/mul_nibble_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier built from an external 4x4 combinational
// multiplier. Each RUN cycle handles one nibble pair and adds the shifted partial product.
module mul_nibble_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [6:0]         opcode,
   input  logic               flush,
   output logic [3:0]         mult_a,
   output logic [3:0]         mult_b,
   input  logic [7:0]         mult_p,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [2*WIDTH-1:0] product,
   output logic [6:0]         result_opcode,
   output logic               busy
);

   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [6:0]         opc_q;
   logic [PW-1:0]      acc;
   logic [CW-1:0]      i, j;
   logic [CW:0]        nib_sum;
   logic [PW-1:0]      pp;

   // j walks the multiplicand nibbles (inner loop), i the multiplier nibbles.
   assign mult_a  = (state == RUN) ? a_q[4*j +: 4] : 4'd0;
   assign mult_b  = (state == RUN) ? b_q[4*i +: 4] : 4'd0;
   assign nib_sum = {1'b0, i} + {1'b0, j};
   assign pp      = PW'(mult_p) << {nib_sum, 2'b00};

   assign start_ready   = (state == IDLE);
   assign busy          = (state != IDLE);
   assign result_valid  = (state == DONE);
   assign product       = (state == DONE) ? acc : '0;
   assign result_opcode = opc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         opc_q <= '0;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
      end else if (flush) begin
         // Abort wins over start, handshake and the RUN step.
         state <= IDLE;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_q   <= multiplicand;
                  b_q   <= multiplier;
                  opc_q <= opcode;
                  acc   <= '0;
                  i     <= '0;
                  j     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= acc + pp;
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     i     <= '0;
                     state <= DONE;
                  end else begin
                     i <= i + 1'b1;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end
            DONE: begin
               if (result_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
